mef_rega_ctrl: RTL and testbench
================================

Name: mef_rega_ctrl

Overview:
- Sequential irrigation controller directly downstream of the irrigation-validation stage.
- Consumes the validated irrigation request `rega[1:0]` and the validation `erro` flag.
- Debounces the request, sequences valve opening, enforces a minimum irrigation time, and latches faults until the operator acknowledges them.
- Drives the sprinkler (aspersão) and drip (gotejamento) valve actuators.

Parameters:
- DEB, 4: consecutive cycles a request code must be stable before it is accepted (≥1).
- T_ABRE, 8: cycles spent in valve-opening phase before irrigation counts as active (≥1).
- T_MIN, 32: minimum cycles in REGANDO before a request drop is honoured (≥1).
- CW, 8: internal counter width; must satisfy 2^CW > max(DEB, T_ABRE, T_MIN).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rega  in  2  validated request from upstream: 10 = sprinkler, 01 = drip, 00 = none, 11 = illegal
- erro  in  1  validation error from upstream
- ack_erro  in  1  operator fault acknowledge, level-sensitive
- valv_asp  out  1  sprinkler valve drive, registered
- valv_got  out  1  drip valve drive, registered
- alarme  out  1  fault indicator, registered
- estado  out  2  current state code, registered
- regando  out  1  high only in REGANDO, registered

Behaviour:
- Clocking and reset:
  - One clock domain; clk and reset_n.
  - Reset is asynchronous and active-low.
  - During reset all outputs are 0, state is IDLE, and the counter, latched mode and debounce register are cleared.
  - Reset asserted mid-operation closes both valves immediately, asynchronously.
- State encoding: IDLE = 00, ABRINDO = 01, REGANDO = 10, ERRO = 11. `estado` mirrors the state register.
- All outputs are registered. They reflect the state entered on the same edge, so there is 1-cycle latency from a sampled input to an output change.
- Fault priority:
  - In any non-ERRO state, erro = 1 or rega = 11 sampled at an edge → ERRO on that edge.
  - On entering ERRO: both valves 0, alarme 1, counter cleared.
  - Fault beats every other transition on the same cycle.
- IDLE:
  - Debounce tracks the last sampled rega code. The counter increments while the code equals the previous sample and is nonzero; it resets to 0 on any change or on 00.
  - When the counter reaches DEB-1 with the same code still present (DEB consecutive equal samples) → ABRINDO.
  - On that transition, latch the mode (10 or 01) and clear the counter.
- ABRINDO:
  - The latched valve output is 1 from the first ABRINDO cycle; the other valve is 0.
  - Counter increments each cycle. At count T_ABRE-1 → REGANDO, counter cleared.
  - rega ≠ latched mode (00 or the other mode) during ABRINDO → IDLE, valves 0. No minimum time applies here.
- REGANDO:
  - Latched valve stays 1; regando = 1.
  - Counter increments and saturates at T_MIN-1.
  - If rega ≠ latched mode and the counter is saturated → IDLE, valves 0.
  - If rega ≠ latched mode before saturation, stay in REGANDO until saturation, then exit if the mismatch persists. A request returning to the latched mode cancels the pending exit.
- Mode change:
  - A direct change between sprinkler and drip is never allowed; the path is REGANDO → IDLE → full debounce → ABRINDO.
  - Both valves are never 1 simultaneously in any state, including across transitions.
- ERRO:
  - Exit to IDLE only on a cycle where ack_erro = 1 and erro = 0 and rega ≠ 11.
  - ack_erro while the fault persists is ignored. ack_erro outside ERRO is ignored.
  - After exit the debounce restarts from 0: a request held throughout ERRO still needs DEB fresh cycles in IDLE.
- Counter arithmetic: unsigned, CW bits, never wraps. It is cleared on every state transition.

Decomposition:
- Shared package `rega_pkg`:
  - State typedef/localparams ST_IDLE, ST_ABRINDO, ST_REGANDO, ST_ERRO.
  - Request codes REGA_NONE = 00, REGA_GOT = 01, REGA_ASP = 10, REGA_ILEGAL = 11. The upstream validation stage uses the same codes.
- One natural sub-module, `rega_debounce`: stability counter plus last-code register. It takes rega, clear and DEB, and outputs `estavel` and `codigo`. The FSM and timers stay in the top.

Test Plan (defaults DEB=4, T_ABRE=8, T_MIN=32):
- Reset, then rega = 10 held → valv_asp rises 5 cycles after rega applied; regando rises 8 cycles later; valv_got stays 0 throughout.
- In REGANDO with drip latched, drop rega to 00 at REGANDO cycle 5 → valv_got stays 1 until REGANDO count 31, then 0 the next cycle, estado = 00.
- rega toggles 01/00 every 2 cycles for 40 cycles → never leaves IDLE; valves stay 0.
- In REGANDO, assert erro for 1 cycle → next edge estado = 11, both valves 0, alarme 1. ack_erro while erro = 1 keeps ERRO. ack_erro with erro = 0 → IDLE, alarme 0; the held request needs 4 new cycles.
- rega = 11 in IDLE → ERRO next edge. In REGANDO with sprinkler latched, switch rega to 01 → sprinkler closes after minimum time, then drip opens only after a fresh debounce; the valves never overlap.
- Assert reset_n low mid-ABRINDO asynchronously → valves 0 before the next clock edge; estado = 00 after release.

Source files
------------

// File: rtl/mef_rega_ctrl_pkg.sv
// Shared state and request codes for the irrigation controller slice.
// The upstream validation stage uses the same request encoding.
package rega_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ABRINDO = 2'b01,
        ST_REGANDO = 2'b10,
        ST_ERRO    = 2'b11
    } estado_t;

    localparam logic [1:0] REGA_NONE   = 2'b00;
    localparam logic [1:0] REGA_GOT    = 2'b01;
    localparam logic [1:0] REGA_ASP    = 2'b10;
    localparam logic [1:0] REGA_ILEGAL = 2'b11;

    function automatic logic falha(input logic [1:0] rega, input logic erro);
        return erro || (rega == REGA_ILEGAL);
    endfunction

endpackage

// File: rtl/mef_rega_ctrl_if.sv
// Request/fault inputs and valve/status outputs of the irrigation controller.
interface mef_rega_ctrl_if;
    logic [1:0] rega;
    logic       erro;
    logic       ack_erro;
    logic       valv_asp;
    logic       valv_got;
    logic       alarme;
    logic [1:0] estado;
    logic       regando;

    modport master (
        output rega, erro, ack_erro,
        input  valv_asp, valv_got, alarme, estado, regando
    );

    modport slave (
        input  rega, erro, ack_erro,
        output valv_asp, valv_got, alarme, estado, regando
    );
endinterface

// File: rtl/mef_rega_ctrl_debounce.sv
// Request debounce: a nonzero code must repeat DEB times after its first sample.
module rega_debounce
    import rega_pkg::*;
#(
    parameter int unsigned DEB = 4,
    parameter int unsigned CW  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] rega,
    input  logic       clear,
    output logic       estavel,
    output logic [1:0] codigo
);

    localparam logic [CW-1:0] FIM = CW'(DEB - 1);

    logic [CW-1:0] cnt;
    logic          igual;

    assign igual   = (rega == codigo) && (rega != REGA_NONE);
    assign estavel = igual && (cnt == FIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            codigo <= REGA_NONE;
        end else if (clear) begin
            cnt    <= '0;
            codigo <= REGA_NONE;
        end else begin
            codigo <= rega;
            if (!igual)
                cnt <= '0;
            else if (cnt != FIM)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mef_rega_ctrl.sv
// Irrigation controller FSM: debounced request, timed valve opening,
// minimum irrigation time and latched faults released by operator ack.
module mef_rega_ctrl
    import rega_pkg::*;
#(
    parameter int unsigned DEB    = 4,
    parameter int unsigned T_ABRE = 8,
    parameter int unsigned T_MIN  = 32,
    parameter int unsigned CW     = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    mef_rega_ctrl_if.slave  bus
);

    localparam logic [CW-1:0] ABRE_FIM = CW'(T_ABRE - 1);
    localparam logic [CW-1:0] MIN_FIM  = CW'(T_MIN - 1);

    estado_t       state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    modo, modo_n;
    logic          valv_asp, valv_got, alarme, regando;
    logic          valv_asp_n, valv_got_n, alarme_n, regando_n;
    logic          estavel;
    logic [1:0]    codigo;
    logic          deb_clear;

    // Debounce only runs while sitting in IDLE, so every return to IDLE restarts it.
    assign deb_clear = (state != ST_IDLE);

    rega_debounce #(
        .DEB (DEB),
        .CW  (CW)
    ) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .rega    (bus.rega),
        .clear   (deb_clear),
        .estavel (estavel),
        .codigo  (codigo)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        modo_n  = modo;
        case (state)
            ST_IDLE: begin
                if (falha(bus.rega, bus.erro)) begin
                    state_n = ST_ERRO;
                end else if (estavel) begin
                    state_n = ST_ABRINDO;
                    modo_n  = codigo;
                end
            end
            ST_ABRINDO: begin
                if (falha(bus.rega, bus.erro))
                    state_n = ST_ERRO;
                else if (bus.rega != modo)
                    state_n = ST_IDLE;
                else if (cnt == ABRE_FIM)
                    state_n = ST_REGANDO;
                else
                    cnt_n = cnt + 1'b1;
            end
            ST_REGANDO: begin
                // A dropped request is held off until the minimum time has elapsed.
                if (falha(bus.rega, bus.erro))
                    state_n = ST_ERRO;
                else if ((bus.rega != modo) && (cnt == MIN_FIM))
                    state_n = ST_IDLE;
                else if (cnt != MIN_FIM)
                    cnt_n = cnt + 1'b1;
            end
            ST_ERRO: begin
                if (bus.ack_erro && !bus.erro && (bus.rega != REGA_ILEGAL))
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (state_n != state)
            cnt_n = '0;

        valv_asp_n = ((state_n == ST_ABRINDO) || (state_n == ST_REGANDO)) && (modo_n == REGA_ASP);
        valv_got_n = ((state_n == ST_ABRINDO) || (state_n == ST_REGANDO)) && (modo_n == REGA_GOT);
        alarme_n   = (state_n == ST_ERRO);
        regando_n  = (state_n == ST_REGANDO);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            modo     <= REGA_NONE;
            valv_asp <= 1'b0;
            valv_got <= 1'b0;
            alarme   <= 1'b0;
            regando  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            modo     <= modo_n;
            valv_asp <= valv_asp_n;
            valv_got <= valv_got_n;
            alarme   <= alarme_n;
            regando  <= regando_n;
        end
    end

    assign bus.valv_asp = valv_asp;
    assign bus.valv_got = valv_got;
    assign bus.alarme   = alarme;
    assign bus.regando  = regando;
    assign bus.estado   = state;

endmodule

// File: tb/tb_mef_rega_ctrl.sv
// Directed bench for mef_rega_ctrl with DEB=4, T_ABRE=8, T_MIN=32.
module tb_mef_rega_ctrl;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] GOT  = 2'b01;
    localparam logic [1:0] ASP  = 2'b10;
    localparam logic [1:0] ILG  = 2'b11;

    mef_rega_ctrl_if bus();

    mef_rega_ctrl #(
        .DEB    (4),
        .T_ABRE (8),
        .T_MIN  (32),
        .CW     (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Valves must never be open together, in any state or transition.
    always @(negedge clk)
        if (reset_n)
            check("sobrepoe", {31'b0, bus.valv_asp & bus.valv_got}, 32'd0);

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b1;
        bus.rega     = NONE;
        bus.erro     = 1'b0;
        bus.ack_erro = 1'b0;
        #2 reset_n = 1'b0;
        cyc(2);
        check("rst_estado", {30'b0, bus.estado}, 32'd0);
        check("rst_asp",    {31'b0, bus.valv_asp}, 32'd0);
        check("rst_got",    {31'b0, bus.valv_got}, 32'd0);
        check("rst_alarme", {31'b0, bus.alarme}, 32'd0);
        check("rst_regando",{31'b0, bus.regando}, 32'd0);
        reset_n = 1'b1;

        // Sprinkler request: opens 5 edges after applied, irrigating 8 edges later
        bus.rega = ASP;
        cyc(4);
        check("asp_deb_estado", {30'b0, bus.estado}, 32'd0);
        check("asp_deb_valv",   {31'b0, bus.valv_asp}, 32'd0);
        cyc(1);
        check("asp_abre_valv",  {31'b0, bus.valv_asp}, 32'd1);
        check("asp_abre_got",   {31'b0, bus.valv_got}, 32'd0);
        check("asp_abre_estado",{30'b0, bus.estado}, 32'd1);
        cyc(7);
        check("asp_abre_reg",   {31'b0, bus.regando}, 32'd0);
        cyc(1);
        check("asp_reg",        {31'b0, bus.regando}, 32'd1);
        check("asp_reg_estado", {30'b0, bus.estado}, 32'd2);

        // Switch to drip: sprinkler closes only after minimum time, drip needs fresh debounce
        bus.rega = GOT;
        cyc(31);
        check("troca_min_asp",  {31'b0, bus.valv_asp}, 32'd1);
        check("troca_min_est",  {30'b0, bus.estado}, 32'd2);
        cyc(1);
        check("troca_fim_asp",  {31'b0, bus.valv_asp}, 32'd0);
        check("troca_fim_est",  {30'b0, bus.estado}, 32'd0);
        cyc(4);
        check("troca_deb_got",  {31'b0, bus.valv_got}, 32'd0);
        cyc(1);
        check("troca_got",      {31'b0, bus.valv_got}, 32'd1);
        check("troca_got_est",  {30'b0, bus.estado}, 32'd1);

        // Drip irrigating, request dropped at REGANDO count 5
        cyc(8);
        check("got_reg",        {31'b0, bus.regando}, 32'd1);
        cyc(5);
        bus.rega = NONE;
        cyc(26);
        check("got_min_valv",   {31'b0, bus.valv_got}, 32'd1);
        check("got_min_est",    {30'b0, bus.estado}, 32'd2);
        cyc(1);
        check("got_fim_valv",   {31'b0, bus.valv_got}, 32'd0);
        check("got_fim_est",    {30'b0, bus.estado}, 32'd0);
        check("got_fim_reg",    {31'b0, bus.regando}, 32'd0);

        // Chattering request never passes debounce
        for (int i = 0; i < 20; i++) begin
            bus.rega = (i % 2 == 0) ? GOT : NONE;
            cyc(2);
            check("chatter_est", {30'b0, bus.estado}, 32'd0);
            check("chatter_got", {31'b0, bus.valv_got}, 32'd0);
        end

        // Fault during REGANDO, ack ignored while fault persists
        bus.rega = ASP;
        cyc(13);
        check("erro_pre_reg",   {31'b0, bus.regando}, 32'd1);
        bus.erro = 1'b1;
        cyc(1);
        check("erro_est",       {30'b0, bus.estado}, 32'd3);
        check("erro_asp",       {31'b0, bus.valv_asp}, 32'd0);
        check("erro_alarme",    {31'b0, bus.alarme}, 32'd1);
        check("erro_reg",       {31'b0, bus.regando}, 32'd0);
        bus.ack_erro = 1'b1;
        cyc(2);
        check("erro_ack_ign",   {30'b0, bus.estado}, 32'd3);
        bus.erro = 1'b0;
        cyc(1);
        check("erro_sai_est",   {30'b0, bus.estado}, 32'd0);
        check("erro_sai_alm",   {31'b0, bus.alarme}, 32'd0);
        bus.ack_erro = 1'b0;
        cyc(4);
        check("erro_deb_est",   {30'b0, bus.estado}, 32'd0);
        check("erro_deb_asp",   {31'b0, bus.valv_asp}, 32'd0);
        cyc(1);
        check("erro_reabre",    {31'b0, bus.valv_asp}, 32'd1);
        check("erro_reabre_est",{30'b0, bus.estado}, 32'd1);

        // Asynchronous reset mid-ABRINDO closes the valve before the next edge
        #2 reset_n = 1'b0;
        #1;
        check("arst_asp",       {31'b0, bus.valv_asp}, 32'd0);
        check("arst_est",       {30'b0, bus.estado}, 32'd0);
        bus.rega = NONE;
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        check("arst_pos_est",   {30'b0, bus.estado}, 32'd0);

        // ack outside ERRO is ignored; illegal code faults immediately
        bus.ack_erro = 1'b1;
        cyc(2);
        check("ack_idle_est",   {30'b0, bus.estado}, 32'd0);
        check("ack_idle_alm",   {31'b0, bus.alarme}, 32'd0);
        bus.ack_erro = 1'b0;
        bus.rega = ILG;
        cyc(1);
        check("ilg_est",        {30'b0, bus.estado}, 32'd3);
        check("ilg_alm",        {31'b0, bus.alarme}, 32'd1);
        bus.ack_erro = 1'b1;
        cyc(1);
        check("ilg_ack_ign",    {30'b0, bus.estado}, 32'd3);
        bus.rega = NONE;
        cyc(1);
        check("ilg_sai_est",    {30'b0, bus.estado}, 32'd0);
        check("ilg_sai_alm",    {31'b0, bus.alarme}, 32'd0);
        bus.ack_erro = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
